// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage: one op at a time,
// shift-add multiply and restoring divide at one bit per cycle, sign fixup at the end.
module ex_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] pc_o
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;
  state_t r_state;

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic            r_word, r_spec, r_neg, r_neg_rem;
  logic [XLEN-1:0] r_hi, r_lo, r_opb, r_pc;
  logic [4:0]      r_rd;

  function automatic logic [XLEN-1:0] sext_h(input logic [HW-1:0] v);
    return {{HW{v[HW-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_h(input logic [HW-1:0] v);
    return {{HW{1'b0}}, v};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  logic            w_accept, w_word, w_sgn_a, w_sgn_b, w_a_neg, w_b_neg;
  logic            w_b_zero, w_ovf, w_spec, w_last, w_ge;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_res, w_min, w_spec_val;
  logic [XLEN-1:0] w_addend, w_diff, w_mul_res, w_div_raw, w_res;
  logic [XLEN:0]   w_sum, w_rsh;
  logic [2*XLEN-1:0] w_prod;

  // Accept-time decode: operand magnitudes, signs and the no-iteration division cases
  always_comb begin
    w_accept = start_i && !busy_o && !flush_i;
    w_word   = word_i && (funct3_i == 3'd0 || funct3_i[2]);
    w_sgn_a  = funct3_i inside {3'd1, 3'd2, 3'd4, 3'd6};
    w_sgn_b  = funct3_i inside {3'd1, 3'd4, 3'd6};
    w_a_ext  = src1_i;
    w_b_ext  = src2_i;
    if (w_word) begin
      w_a_ext = w_sgn_a ? sext_h(src1_i[HW-1:0]) : zext_h(src1_i[HW-1:0]);
      w_b_ext = w_sgn_b ? sext_h(src2_i[HW-1:0]) : zext_h(src2_i[HW-1:0]);
    end
    w_a_neg    = w_sgn_a && w_a_ext[XLEN-1];
    w_b_neg    = w_sgn_b && w_b_ext[XLEN-1];
    w_a_mag    = cond_neg(w_a_neg, w_a_ext);
    w_b_mag    = cond_neg(w_b_neg, w_b_ext);
    w_a_res    = w_word ? sext_h(src1_i[HW-1:0]) : src1_i;
    w_min      = w_word ? sext_h({1'b1, {(HW-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
    w_b_zero   = (w_b_ext == '0);
    w_ovf      = w_sgn_b && funct3_i[2] && (w_a_ext == w_min) && (&w_b_ext);
    w_spec     = funct3_i[2] && (w_b_zero || w_ovf);
    if (funct3_i[1]) w_spec_val = w_b_zero ? w_a_res : '0;
    else             w_spec_val = w_b_zero ? '1 : w_a_res;
  end

  // Per-iteration step: multiply adds into the high half then shifts right,
  // divide shifts a dividend bit into the remainder and trial-subtracts
  always_comb begin
    w_addend = r_lo[0] ? r_opb : '0;
    w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    w_rsh    = {r_hi, r_lo[XLEN-1]};
    w_ge     = (w_rsh >= {1'b0, r_opb});
    w_diff   = w_rsh[XLEN-1:0] - r_opb;
    w_last   = (r_cnt == (r_word ? CW'(HW - 1) : CW'(XLEN - 1)));
  end

  // Fixup: restore signs; a word multiply's 32x32 product sits one half-word up
  always_comb begin
    w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    if (r_f3 == 3'd0) w_mul_res = r_word ? sext_h(r_lo[XLEN-1:HW]) : w_prod[XLEN-1:0];
    else              w_mul_res = w_prod[2*XLEN-1:XLEN];
    w_div_raw = r_f3[1] ? cond_neg(r_neg_rem, r_hi) : cond_neg(r_neg, r_lo);
    if (r_spec)       w_res = r_lo;
    else if (!r_f3[2]) w_res = w_mul_res;
    else              w_res = r_word ? sext_h(w_div_raw[HW-1:0]) : w_div_raw;
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_f3      <= funct3_i;
      r_word    <= w_word;
      r_spec    <= w_spec;
      r_neg     <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_rd      <= rd_i;
      r_pc      <= pc_i;
      r_hi      <= '0;
      r_opb     <= funct3_i[2] ? w_b_mag : w_a_mag;
      if (w_spec)           r_lo <= w_spec_val;
      else if (funct3_i[2]) r_lo <= w_word ? {w_a_mag[HW-1:0], {HW{1'b0}}} : w_a_mag;
      else                  r_lo <= w_b_mag;
    end else if (r_state == S_CALC) begin
      if (!r_f3[2]) begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end else begin
        r_hi <= w_ge ? w_diff : w_rsh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
      pc_o     <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done_o <= 1'b0;
          r_cnt  <= '0;
          if (w_accept) begin
            r_state <= w_spec ? S_FIXUP : S_CALC;
            busy_o  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_state  <= S_DONE;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
          result_o <= w_res;
          rd_o     <= r_rd;
          pc_o     <= r_pc;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed ops push expectations, a negedge monitor
// pops and compares result/rd/pc/latency whenever done_o pulses.
module tb_ex_muldiv;
  logic        clock, reset, start_i, word_i, flush_i;
  logic [2:0]  funct3_i;
  logic [63:0] src1_i, src2_i, pc_i;
  logic [4:0]  rd_i;
  logic        busy_o, done_o;
  logic [63:0] result_o, pc_o;
  logic [4:0]  rd_o;

  ex_muldiv #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
    .word_i(word_i), .src1_i(src1_i), .src2_i(src2_i), .rd_i(rd_i), .pc_i(pc_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .rd_o(rd_o), .pc_o(pc_o)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic [63:0] pc;
    int          c0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINI = 64'h8000_0000_0000_0000;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done_o=1 rd_o=%0d expected no completion", rd_o);
      end else begin
        e = sb.pop_front();
        check($sformatf("result rd%0d", e.rd), result_o, e.res);
        check($sformatf("rd rd%0d", e.rd), 64'(rd_o), 64'(e.rd));
        check($sformatf("pc rd%0d", e.rd), pc_o, e.pc);
        check($sformatf("latency rd%0d", e.rd), 64'(cyc - e.c0 + 1), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] pc, input logic push,
                       input logic [63:0] exp, input int lat);
    exp_t e;
    start_i = 1'b1; funct3_i = f3; word_i = w; src1_i = a; src2_i = b; rd_i = rd; pc_i = pc;
    @(posedge clock); #1;
    start_i = 1'b0;
    if (push) begin
      e.res = exp; e.rd = rd; e.pc = pc; e.c0 = cyc; e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(negedge clock);
      i++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d ops pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] rd, input logic [63:0] exp, input int lat);
    @(negedge clock);
    issue(f3, w, a, b, rd, 64'h1000 + 64'(rd) * 4, 1'b1, exp, lat);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; word_i = 1'b0; funct3_i = 3'd0;
    src1_i = '0; src2_i = '0; rd_i = '0; pc_i = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset rd", 64'(rd_o), 64'd0);
    check("reset pc", pc_o, 64'd0);

    run(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, 66);
    run(3'd3, 1'b1, ONES, ONES, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run(3'd1, 1'b0, ONES, ONES, 5'd3, 64'd0, 66);
    run(3'd2, 1'b0, ONES, 64'd2, 5'd4, ONES, 66);
    run(3'd4, 1'b0, 64'd7, 64'd0, 5'd5, ONES, 2);
    run(3'd6, 1'b0, 64'd7, 64'd0, 5'd6, 64'd7, 2);
    run(3'd4, 1'b0, MINI, ONES, 5'd7, MINI, 2);
    run(3'd6, 1'b0, MINI, ONES, 5'd8, 64'd0, 2);
    run(3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    run(3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, ONES, 34);
    run(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd11, ONES, 34);
    run(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run(3'd4, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 5'd13, ONES, 2);
    run(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd14, 64'hFFFF_FFFF_8000_0000, 2);
    run(3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd15, 64'd0, 2);
    run(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd16, ONES, 66);

    // Back-to-back: second op accepted in the DONE cycle of the first
    @(negedge clock);
    issue(3'd5, 1'b0, 64'd100, 64'd7, 5'd17, 64'h2000, 1'b1, 64'd14, 66);
    i = 0;
    while (done_o !== 1'b1 && i < 100) begin
      @(negedge clock);
      i++;
    end
    if (done_o !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_first_done: got no done_o expected a completion");
    end
    issue(3'd7, 1'b0, 64'd100, 64'd7, 5'd18, 64'h2004, 1'b1, 64'd2, 66);
    wait_idle();

    // Start while busy is dropped
    @(negedge clock);
    issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd19, 64'h3000, 1'b1, 64'd42, 66);
    repeat (4) @(negedge clock);
    start_i = 1'b1; funct3_i = 3'd0; src1_i = 64'd1; src2_i = 64'd1; rd_i = 5'd20; pc_i = 64'h3004;
    repeat (3) @(negedge clock);
    start_i = 1'b0;
    check("busy held", 64'(busy_o), 64'd1);
    wait_idle();

    // Flush mid-multiply: no completion, outputs keep the previous op
    @(negedge clock);
    issue(3'd0, 1'b0, 64'd9, 64'd9, 5'd21, 64'h4000, 1'b0, 64'd0, 0);
    repeat (9) @(negedge clock);
    flush_i = 1'b1;
    @(posedge clock); #1;
    flush_i = 1'b0;
    @(negedge clock);
    check("flush busy", 64'(busy_o), 64'd0);
    check("flush done", 64'(done_o), 64'd0);
    check("flush result", result_o, 64'd42);
    check("flush rd", 64'(rd_o), 64'd19);
    check("flush pc", pc_o, 64'h3000);

    // Flush and start in the same cycle: start is dropped
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; src1_i = 64'd2; src2_i = 64'd2; rd_i = 5'd23;
    @(posedge clock); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clock);
    check("flush_start busy", 64'(busy_o), 64'd0);
    repeat (80) @(negedge clock);
    check("flush quiet result", result_o, 64'd42);

    // Reset mid-op behaves like power-on reset
    issue(3'd0, 1'b0, 64'd11, 64'd13, 5'd22, 64'h5000, 1'b0, 64'd0, 0);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midreset busy", 64'(busy_o), 64'd0);
    check("midreset done", 64'(done_o), 64'd0);
    check("midreset result", result_o, 64'd0);
    check("midreset rd", 64'(rd_o), 64'd0);
    check("midreset pc", pc_o, 64'd0);
    repeat (80) @(negedge clock);
    check("midreset quiet result", result_o, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
